// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES round controller driving a shared single-round core
//
// Purpose:
//   Owns the 128-bit cipher state, the round counter and the round-key index.
//   A block accepted in IDLE is pushed through NR+1 round-core passes (first,
//   NR-1 middle, last). Each pass XORs the core result with the round key.
//   The ciphertext is then presented in DONE until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     plaintext handshake, in_data[127:120] is byte 0
//   out_valid/out_ready   ciphertext handshake, out_data held while stalled
//   busy                  high while rounds are executing
//   core_din/core_sel     state and round type (00 first, 01 middle, 10 last) to the core
//   core_dout             combinational round-core result, before key addition
//   rk_idx/rk_data        round-key index and the key returned in the same cycle
//   perf_blocks           completed-block counter, present only with AES_SEQ_PERF_EN
//
// Optional build macro: AES_SEQ_PERF_EN

module aes_round_sequencer #(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic           busy,
    output logic [127:0]   core_din,
    output logic [1:0]     core_sel,
    input  logic [127:0]   core_dout,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   rk_data
`ifdef AES_SEQ_PERF_EN
    ,
    output logic [31:0]    perf_blocks
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ROUND = 2'b01,
        DONE  = 2'b10
    } fsm_e;

    localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);

    localparam logic [1:0] SEL_FIRST  = 2'b00;
    localparam logic [1:0] SEL_MIDDLE = 2'b01;
    localparam logic [1:0] SEL_LAST   = 2'b10;

    fsm_e           fsm_q,   fsm_d;
    logic [127:0]   state_q, state_d;
    logic [RKW-1:0] round_q, round_d;
    // Holds in_ready low during reset and for nothing else: it goes high on
    // the first clock edge after rst_n releases and stays there.
    logic           init_q,  init_d;

`ifdef AES_SEQ_PERF_EN
    logic [31:0]    perf_q,  perf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            init_q  <= 1'b0;
`ifdef AES_SEQ_PERF_EN
            perf_q  <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            init_q  <= init_d;
`ifdef AES_SEQ_PERF_EN
            perf_q  <= perf_d;
`endif
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        init_d    = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        // Outside ROUND the core sees a quiescent all-zero input.
        core_din  = '0;
        core_sel  = SEL_FIRST;
        rk_idx    = '0;

        case (fsm_q)
            IDLE: begin
                in_ready = init_q;
                if (in_valid && init_q) begin
                    state_d = in_data;
                    round_d = '0;
                    fsm_d   = ROUND;
                end
            end

            ROUND: begin
                busy     = 1'b1;
                core_din = state_q;
                rk_idx   = round_q;
                if (round_q == '0) begin
                    core_sel = SEL_FIRST;
                end else if (round_q == LAST_ROUND) begin
                    core_sel = SEL_LAST;
                end else begin
                    core_sel = SEL_MIDDLE;
                end

                state_d = core_dout ^ rk_data;
                // The counter clears at the last round rather than wrapping,
                // so values above NR never occur.
                if (round_q == LAST_ROUND) begin
                    round_d = '0;
                    fsm_d   = DONE;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                out_data  = state_q;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

`ifdef AES_SEQ_PERF_EN
    always_comb begin
        perf_d = perf_q;
        if (fsm_q == DONE && out_ready) begin
            perf_d = perf_q + 32'd1;
        end
    end

    assign perf_blocks = perf_q;
`endif

endmodule
